// File: rtl/emu_clk_pkg.sv
// Shared types and constants for the 6502 emulation cycle sequencer.
// State encoding and mode values are used by the sequencer and its bench.
package emu_clk_pkg;

    typedef enum logic [2:0] {
        ST_RES_HOLD = 3'd0,
        ST_PH1      = 3'd1,
        ST_PH2      = 3'd2,
        ST_HALT     = 3'd3,
        ST_STEP1    = 3'd4,
        ST_STEP2    = 3'd5
    } emu_state_t;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_HALT = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

endpackage

// File: rtl/emu_div_counter.sv
// Half-cycle down-counter: reloads on load, otherwise counts down freely.
// tc flags the last eclk of the current phase.
module emu_div_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = load ? load_val : (count_q - W'(1));
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;
    assign tc    = (count_q == '0);

endmodule

// File: rtl/emu_cycle_ctrl.sv
// Two-phase CPU clock sequencer for the emulated 6502: programmable speed,
// run/halt/step modes, stretched CPU reset and a retired-cycle counter.
module emu_cycle_ctrl
    import emu_clk_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int RES_CYCLES = 8,
    parameter int CNT_W      = 32
) (
    input  logic             eclk,
    input  logic             ereset,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       mode,
    input  logic             step_req,
    input  logic             cpu_res_req,
    output logic             phi2,
    output logic             ph1_start,
    output logic             ph2_start,
    output logic             res_n,
    output logic             halted,
    output logic             step_ack,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int RC_W = (RES_CYCLES > 1) ? $clog2(RES_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RES_CYCLES - 1);

    emu_state_t       state_q, state_d;
    logic             phi2_q, phi2_d;
    logic             ph1_start_q, ph1_start_d;
    logic             ph2_start_q, ph2_start_d;
    logic             res_n_q, res_n_d;
    logic             halted_q, halted_d;
    logic             step_ack_q, step_ack_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [RC_W-1:0]  res_cnt_q, res_cnt_d;
    logic             res_pend_q, res_pend_d;

    logic             enter;
    logic             tc;
    logic [DIV_W-1:0] div_count;
    logic             step_ok;
    logic             run_sel;

    emu_div_counter #(.W(DIV_W)) u_div (
        .clk      (eclk),
        .load     (ereset | enter),
        .load_val (div),
        .count    (div_count),
        .tc       (tc)
    );

    assign run_sel = (mode == MODE_RUN);
    assign step_ok = (mode == MODE_STEP) || (mode == MODE_HALT) || (mode == (MODE_STEP | MODE_HALT));

    always_comb begin
        state_d     = state_q;
        phi2_d      = phi2_q;
        res_cnt_d   = res_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        res_pend_d  = res_pend_q;
        enter       = 1'b0;

        if (state_q == ST_HALT) begin
            phi2_d = 1'b0;
            if (cpu_res_req) begin
                state_d     = ST_RES_HOLD;
                enter       = 1'b1;
                res_cnt_d   = '0;
                cycle_cnt_d = '0;
                res_pend_d  = 1'b0;
            end else if (step_req && step_ok) begin
                state_d = ST_STEP1;
                enter   = 1'b1;
            end else if (run_sel) begin
                state_d = ST_PH1;
                enter   = 1'b1;
            end
        end else if (!tc) begin
            // A reset request mid-phase waits for the next phase-1 entry.
            res_pend_d = res_pend_q | cpu_res_req;
        end else if (!phi2_q) begin
            enter      = 1'b1;
            phi2_d     = 1'b1;
            res_pend_d = res_pend_q | cpu_res_req;
            case (state_q)
                ST_PH1:   state_d = ST_PH2;
                ST_STEP1: state_d = ST_STEP2;
                default:  state_d = state_q;
            endcase
        end else begin
            enter  = 1'b1;
            phi2_d = 1'b0;
            if (cpu_res_req || res_pend_q) begin
                state_d     = ST_RES_HOLD;
                res_cnt_d   = '0;
                cycle_cnt_d = '0;
                res_pend_d  = 1'b0;
            end else begin
                case (state_q)
                    ST_RES_HOLD: begin
                        if (res_cnt_q == RC_LAST) begin
                            state_d = run_sel ? ST_PH1 : ST_HALT;
                        end else begin
                            res_cnt_d = res_cnt_q + RC_W'(1);
                        end
                    end
                    ST_PH2: begin
                        state_d     = run_sel ? ST_PH1 : ST_HALT;
                        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                    end
                    ST_STEP2: begin
                        state_d     = ST_HALT;
                        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                    end
                    default: state_d = ST_HALT;
                endcase
            end
        end

        ph1_start_d = enter && !phi2_d && (state_d != ST_HALT);
        ph2_start_d = enter && phi2_d;
        res_n_d     = (state_d != ST_RES_HOLD);
        halted_d    = (state_d == ST_HALT);
        // Acknowledge shows on the final eclk of the stepped phase 2.
        step_ack_d  = (state_d == ST_STEP2) &&
                      (enter ? (div == '0) : (div_count == DIV_W'(1)));
    end

    always_ff @(posedge eclk) begin
        if (ereset) begin
            state_q     <= ST_RES_HOLD;
            phi2_q      <= 1'b0;
            ph1_start_q <= 1'b1;
            ph2_start_q <= 1'b0;
            res_n_q     <= 1'b0;
            halted_q    <= 1'b0;
            step_ack_q  <= 1'b0;
            cycle_cnt_q <= '0;
            res_cnt_q   <= '0;
            res_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phi2_q      <= phi2_d;
            ph1_start_q <= ph1_start_d;
            ph2_start_q <= ph2_start_d;
            res_n_q     <= res_n_d;
            halted_q    <= halted_d;
            step_ack_q  <= step_ack_d;
            cycle_cnt_q <= cycle_cnt_d;
            res_cnt_q   <= res_cnt_d;
            res_pend_q  <= res_pend_d;
        end
    end

    assign phi2      = phi2_q;
    assign ph1_start = ph1_start_q;
    assign ph2_start = ph2_start_q;
    assign res_n     = res_n_q;
    assign halted    = halted_q;
    assign step_ack  = step_ack_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_emu_cycle_ctrl.sv
// Bench for emu_cycle_ctrl: directed tables and sequences plus randomized
// stimulus, all checked every eclk against a phase-level reference model.
module tb_emu_cycle_ctrl;

    localparam int DIV_W      = 16;
    localparam int RES_CYCLES = 8;
    localparam int CNT_W      = 8;

    logic             eclk = 1'b0;
    logic             ereset = 1'b1;
    logic [DIV_W-1:0] div = '0;
    logic [1:0]       mode = 2'b00;
    logic             step_req = 1'b0;
    logic             cpu_res_req = 1'b0;
    logic             phi2, ph1_start, ph2_start, res_n, halted, step_ack;
    logic [CNT_W-1:0] cycle_cnt;

    emu_cycle_ctrl #(.DIV_W(DIV_W), .RES_CYCLES(RES_CYCLES), .CNT_W(CNT_W)) dut (
        .eclk        (eclk),
        .ereset      (ereset),
        .div         (div),
        .mode        (mode),
        .step_req    (step_req),
        .cpu_res_req (cpu_res_req),
        .phi2        (phi2),
        .ph1_start   (ph1_start),
        .ph2_start   (ph2_start),
        .res_n       (res_n),
        .halted      (halted),
        .step_ack    (step_ack),
        .cycle_cnt   (cycle_cnt)
    );

    always #5 eclk = ~eclk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_model_msgs = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks what kind of CPU cycle is running, which half,
    // and how many eclk remain in that half.
    localparam int K_RES = 0, K_RUN = 1, K_HALT = 2, K_STEP = 3;
    int          m_kind = K_RES, m_half = 0, m_left = 0, m_rescnt = 0, m_pend = 0;
    int unsigned m_cnt = 0;
    logic        m_ph1s = 1'b0, m_ph2s = 1'b0;

    task automatic model_reset_seq(input int dv);
        m_kind = K_RES; m_half = 0; m_left = dv; m_rescnt = 0;
        m_cnt = 0; m_pend = 0; m_ph1s = 1'b1;
    endtask

    task automatic model_step(input logic rst, input int dv, input logic [1:0] md,
                              input logic sreq, input logic rreq);
        m_ph1s = 1'b0;
        m_ph2s = 1'b0;
        if (rst) begin
            model_reset_seq(dv);
        end else if (m_kind == K_HALT) begin
            if (rreq) model_reset_seq(dv);
            else if (sreq && md != 2'b00) begin
                m_kind = K_STEP; m_half = 0; m_left = dv; m_ph1s = 1'b1;
            end else if (md == 2'b00) begin
                m_kind = K_RUN; m_half = 0; m_left = dv; m_ph1s = 1'b1;
            end
        end else if (m_left > 0) begin
            m_left--;
            if (rreq) m_pend = 1;
        end else if (m_half == 0) begin
            m_half = 1; m_left = dv; m_ph2s = 1'b1;
            if (rreq) m_pend = 1;
        end else begin
            m_half = 0; m_left = dv;
            if (rreq || m_pend != 0) begin
                model_reset_seq(dv);
            end else if (m_kind == K_RES) begin
                m_rescnt++;
                if (m_rescnt == RES_CYCLES) m_kind = (md == 2'b00) ? K_RUN : K_HALT;
            end else begin
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                m_kind = (m_kind == K_RUN && md == 2'b00) ? K_RUN : K_HALT;
            end
            if (m_kind != K_HALT) m_ph1s = 1'b1;
        end
    endtask

    function automatic logic [13:0] model_outs();
        logic [5:0] f;
        f[5] = (m_kind != K_HALT) && (m_half == 1);
        f[4] = m_ph1s;
        f[3] = m_ph2s;
        f[2] = (m_kind != K_RES);
        f[1] = (m_kind == K_HALT);
        f[0] = (m_kind == K_STEP) && (m_half == 1) && (m_left == 0);
        return {f, CNT_W'(m_cnt)};
    endfunction

    task automatic tick();
        logic [13:0] act, exp;
        @(posedge eclk);
        model_step(ereset, int'(div), mode, step_req, cpu_res_req);
        #1;
        act = {phi2, ph1_start, ph2_start, res_n, halted, step_ack, cycle_cnt};
        exp = model_outs();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_model_msgs < 20)
                $display("FAIL model {phi2,ph1s,ph2s,res_n,halted,ack,cnt}: got %h expected %h at %0t",
                         act, exp, $time);
            n_model_msgs++;
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            1: return ph1_start;
            2: return ph2_start;
            3: return halted;
            4: return res_n;
            default: return 1'b0;
        endcase
    endfunction

    // Ticks until the selected output is high; n = ticks taken.
    task automatic ticks_until(input int w, input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!sig(w) && n < limit);
        if (!sig(w)) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout waiting for signal %0d: got 0 expected 1", w);
        end
    endtask

    typedef struct {
        int dv;
        int exp_ph1_len;
        int exp_period;
    } spd_t;

    initial begin
        spd_t spd [4];
        int n, n2, c, ph1s_cnt, ph2s_cnt, ack_at, strobes;

        spd[0] = '{dv: 0, exp_ph1_len: 1, exp_period: 2};
        spd[1] = '{dv: 1, exp_ph1_len: 2, exp_period: 4};
        spd[2] = '{dv: 3, exp_ph1_len: 4, exp_period: 8};
        spd[3] = '{dv: 5, exp_ph1_len: 6, exp_period: 12};

        // Reset sequence with div=0, run mode.
        ereset = 1'b1; div = '0; mode = 2'b00;
        tick(); tick();
        check("rst_phi2", phi2, 0);
        check("rst_ph1_start", ph1_start, 1);
        check("rst_ph2_start", ph2_start, 0);
        check("rst_res_n", res_n, 0);
        check("rst_halted", halted, 0);
        check("rst_step_ack", step_ack, 0);
        check("rst_cycle_cnt", cycle_cnt, 0);
        ereset = 1'b0;
        ticks_until(4, 100, n);
        check("res_low_len", n, 16);
        check("res_release_ph1", ph1_start, 1);
        repeat (20) tick();
        check("cnt_after_20", cycle_cnt, 10);
        $display("reset: res_n low %0d eclk, cycle_cnt %0d", n, cycle_cnt);

        // Speed table.
        for (int i = 0; i < 4; i++) begin
            div = DIV_W'(spd[i].dv);
            ticks_until(1, 200, n);
            ticks_until(2, 200, n);
            ticks_until(1, 200, n2);
            check("ph1_len", n, spd[i].exp_ph1_len);
            check("period", n + n2, spd[i].exp_period);
            $display("speed div=%0d: phase1 %0d eclk, period %0d eclk", spd[i].dv, n, n + n2);
        end

        // div change mid-phase.
        div = 16'd3;
        ticks_until(1, 200, n);
        tick();
        div = 16'd1;
        ticks_until(2, 200, n);
        check("div_chg_cur", n + 1, 4);
        ticks_until(1, 200, n);
        check("div_chg_next", n, 2);
        $display("div change: current phase %0d eclk, next %0d eclk", 4, n);

        // Halt during PH1.
        ticks_until(1, 200, n);
        mode = 2'b01;
        c = cycle_cnt;
        ticks_until(3, 50, n);
        check("halt_latency", n, 4);
        check("halt_cnt", cycle_cnt, (c + 1) % 256);
        check("halt_phi2", phi2, 0);
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            strobes += int'(ph1_start) + int'(ph2_start);
        end
        check("halt_strobes", strobes, 0);
        check("halt_cnt_frozen", cycle_cnt, (c + 1) % 256);
        $display("halt: entered after %0d eclk, cycle_cnt %0d", n, cycle_cnt);

        // Single step with div=2, second request during the step is ignored.
        mode = 2'b10; div = 16'd2;
        tick(); tick();
        c = cycle_cnt;
        step_req = 1'b1;
        tick();
        check("step_halted_lo", halted, 0);
        check("step_ph1", ph1_start, 1);
        ph1s_cnt = 1; ph2s_cnt = 0; ack_at = -1;
        for (int t = 2; t <= 12; t++) begin
            tick();
            step_req = 1'b0;
            if (ph1_start) ph1s_cnt++;
            if (ph2_start) ph2s_cnt++;
            if (step_ack) ack_at = t;
            if (t == 7) check("step_halted_again", halted, 1);
        end
        check("step_ack_at", ack_at, 6);
        check("step_ph1_count", ph1s_cnt, 1);
        check("step_ph2_count", ph2s_cnt, 1);
        check("step_cnt", cycle_cnt, (c + 1) % 256);
        $display("step: ack at +%0d, ph1 %0d, ph2 %0d, cycle_cnt %0d", ack_at, ph1s_cnt, ph2s_cnt, cycle_cnt);

        // CPU reset while running with cycle_cnt=100, div=1.
        mode = 2'b00; div = 16'd1;
        n = 0;
        do begin tick(); n++; end while (cycle_cnt != 8'd100 && n < 2000);
        check("reach_100", cycle_cnt, 100);
        check("reach_100_ph1", ph1_start, 1);
        cpu_res_req = 1'b1;
        tick();
        cpu_res_req = 1'b0;
        check("cpures_deferred", res_n, 1);
        tick(); tick();
        check("cpures_still_hi", res_n, 1);
        tick();
        check("cpures_res_n", res_n, 0);
        check("cpures_cnt", cycle_cnt, 0);
        check("cpures_ph1", ph1_start, 1);
        ticks_until(4, 200, n);
        check("cpures_len", n, 32);
        check("cpures_running", halted, 0);
        $display("cpu reset: res_n low %0d eclk", n);

        // Counter wrap.
        div = '0;
        n = 0;
        do begin tick(); n++; end while (cycle_cnt != 8'hFF && n < 2000);
        check("reach_ff", cycle_cnt, 255);
        tick(); tick();
        check("wrap", cycle_cnt, 0);
        $display("wrap: cycle_cnt %0d after 255", cycle_cnt);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) div = DIV_W'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
            step_req    = ($urandom_range(0, 7) == 0);
            cpu_res_req = ($urandom_range(0, 149) == 0);
            ereset      = ($urandom_range(0, 799) == 0);
            tick();
        end
        ereset = 1'b0; step_req = 1'b0; cpu_res_req = 1'b0;
        tick();
        $display("random: 4000 eclk compared against model");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
